id_regread_stage: RTL and testbench
===================================

ID_REGREAD_STAGE -- requirements
Module: id_regread_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register/data width.
REQ-002 SHALL have parameter NUM_REGS, default 16, register count (power of two, >=4).
REQ-003 SHALL have parameter ADDR_W, default 4, register address width, equal to log2(NUM_REGS).
REQ-004 SHALL have parameter ZERO_REG, default NUM_REGS-1, address that reads 0 and ignores writes ("no register").
REQ-005 SHALL have parameter CTRL_W, default 12, width of the opaque decoded-control bundle.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-008 in_valid/in_ready  input/output  1/1  upstream decode handshake.
REQ-009 in_rs1, in_rs2, in_rd  input  ADDR_W each  source/destination register addresses.
REQ-010 in_imm  input  DATA_W  extended immediate; in_ctrl  input  CTRL_W  control bundle; in_is_load  input  1  instruction reads memory.
REQ-011 wb_we  input  1; wb_addr  input  ADDR_W; wb_data  input  DATA_W  write-back port.
REQ-012 flush  input  1  discard held instruction (branch taken).
REQ-013 out_valid/out_ready  output/input  1/1  downstream execute handshake.
REQ-014 out_rs1_data, out_rs2_data, out_imm  output  DATA_W; out_rd  output  ADDR_W; out_ctrl  output  CTRL_W; out_is_load  output  1.
REQ-015 stall_cnt  output  16  count of load-use bubbles inserted.

Function
REQ-016 Register file SHALL hold NUM_REGS x DATA_W words, written on rising clk when wb_we=1 and wb_addr!=ZERO_REG.
REQ-017 Read of ZERO_REG SHALL return 0; read of address equal to wb_addr with wb_we=1 SHALL return wb_data (same-cycle bypass); otherwise stored value.
REQ-018 hazard SHALL be 1 when out_valid=1, out_is_load=1, out_rd!=ZERO_REG, and in_valid=1 and (in_rs1==out_rd or in_rs2==out_rd).
REQ-019 in_ready SHALL equal (out_ready or not out_valid) and not hazard and not flush.
REQ-020 Transfer SHALL occur when in_valid and in_ready; on transfer output register loads read data, in_imm, in_rd, in_ctrl, in_is_load and out_valid<=1 (latency one cycle).
REQ-021 When output may advance (out_ready or not out_valid) without transfer, out_valid SHALL go 0 (bubble); other out_* fields hold.
REQ-022 When out_valid=1 and out_ready=0 and flush=0, all out_* SHALL hold stable.
REQ-023 flush=1 SHALL force out_valid<=0 next cycle regardless of in_valid/out_ready; no transfer that cycle.
REQ-024 stall_cnt SHALL increment by 1 each cycle hazard=1 and out_ready=1, saturating at 16'hFFFF.
REQ-025 Write-back and transfer in the same cycle to the same register SHALL capture wb_data (via REQ-017).

Reset
REQ-026 rst=1 SHALL immediately clear all registers to 0, out_valid, out_is_load, out_* data, stall_cnt to 0, out_rd to ZERO_REG.
REQ-027 rst asserted mid-stall SHALL drop the held instruction; first cycle after release in_ready=1 if out_ready=1.

Verification
REQ-028 Reset, then wb_we=1 wb_addr=3 wb_data=16'h00A5; next cycle in_rs1=3, in_rs2=15 -> out_rs1_data=16'h00A5, out_rs2_data=0 one cycle later.
REQ-029 wb_we=1 wb_addr=15 wb_data=16'hFFFF, then read 15 -> 0.
REQ-030 Load to rd=2 transferred, next instr rs1=2 with out_ready=1 -> in_ready=0 one cycle, bubble out_valid=0, stall_cnt=1, instr issues next cycle.
REQ-031 out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged, in_ready=0; release -> next instruction transfers.
REQ-032 flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, upstream instruction not consumed.
REQ-033 Same-cycle wb_addr=5 wb_data=16'h1234 and transfer with in_rs2=5 -> out_rs2_data=16'h1234.

Source files
------------

// File: rtl/id_regread_stage.sv
// ---------------------------------------------------------------------------
// id_regread_stage
//   Decode / register-read pipeline stage. Holds the architectural register
//   file, reads both source operands (with same-cycle write-back bypass),
//   detects load-use hazards against the instruction held in the output
//   register, and presents a valid/ready handshake on both sides.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid / in_ready          upstream decode handshake
//   in_rs1, in_rs2, in_rd        source / destination register addresses
//   in_imm, in_ctrl, in_is_load  immediate, opaque control bundle, load flag
//   wb_we, wb_addr, wb_data      register-file write-back port
//   flush                        discard held instruction (branch taken)
//   out_valid / out_ready        downstream execute handshake
//   out_rs1_data, out_rs2_data   operand data read for the held instruction
//   out_imm, out_rd, out_ctrl,
//   out_is_load                  fields of the held instruction
//   stall_cnt                    saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_regread_stage #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = NUM_REGS - 1,
   parameter int CTRL_W   = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              in_is_load,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rs1_data,
   output logic [DATA_W-1:0] out_rs2_data,
   output logic [DATA_W-1:0] out_imm,
   output logic [ADDR_W-1:0] out_rd,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_is_load,
   output logic [15:0]       stall_cnt
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] regs_r [NUM_REGS];
   logic [DATA_W-1:0] rs1_data_s;
   logic [DATA_W-1:0] rs2_data_s;
   logic              hazard_s;
   logic              advance_s;
   logic              transfer_s;

   // Register file storage; writes to the "no register" address are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wb_we && (wb_addr != ZERO_ADDR)) begin
         regs_r[wb_addr] <= wb_data;
      end
   end

   // Operand 1 read: zero register, then write-back bypass, then storage.
   always_comb begin
      rs1_data_s = '0;
      if (in_rs1 == ZERO_ADDR) begin
         rs1_data_s = '0;
      end else if (wb_we && (wb_addr == in_rs1)) begin
         rs1_data_s = wb_data;
      end else begin
         rs1_data_s = regs_r[in_rs1];
      end
   end

   // Operand 2 read: same priority as operand 1.
   always_comb begin
      rs2_data_s = '0;
      if (in_rs2 == ZERO_ADDR) begin
         rs2_data_s = '0;
      end else if (wb_we && (wb_addr == in_rs2)) begin
         rs2_data_s = wb_data;
      end else begin
         rs2_data_s = regs_r[in_rs2];
      end
   end

   // Load-use hazard and handshake. The load data is not available until
   // after execute/memory, so a dependent instruction must wait one bubble.
   always_comb begin
      hazard_s   = out_valid && out_is_load && (out_rd != ZERO_ADDR) &&
                   in_valid && ((in_rs1 == out_rd) || (in_rs2 == out_rd));
      advance_s  = out_ready || !out_valid;
      in_ready   = advance_s && !hazard_s && !flush;
      transfer_s = in_valid && in_ready;
   end

   // Output register: flush wins, then transfer, then bubble, else hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_rs1_data <= '0;
         out_rs2_data <= '0;
         out_imm      <= '0;
         out_rd       <= ZERO_ADDR;
         out_ctrl     <= '0;
         out_is_load  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (transfer_s) begin
         out_valid    <= 1'b1;
         out_rs1_data <= rs1_data_s;
         out_rs2_data <= rs2_data_s;
         out_imm      <= in_imm;
         out_rd       <= in_rd;
         out_ctrl     <= in_ctrl;
         out_is_load  <= in_is_load;
      end else if (advance_s) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_valid;
      end
   end

   // Bubble counter: counts cycles where a bubble is actually sent downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 16'h0000;
      end else if (hazard_s && out_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'h0001;
      end else begin
         stall_cnt <= stall_cnt;
      end
   end

endmodule

// File: tb/tb_id_regread_stage.sv
// ---------------------------------------------------------------------------
// tb_id_regread_stage
//   Self-checking bench for id_regread_stage. A behavioural model of the
//   register file, handshake and bubble counter predicts in_ready each cycle;
//   every accepted instruction has its expected output pushed to a scoreboard
//   queue and popped when the output register loads. Directed scenarios add
//   explicit constant checks on top of the model.
// ---------------------------------------------------------------------------
module tb_id_regread_stage;

   localparam logic [3:0] ZR = 4'd15;

   typedef struct {
      logic [15:0] rs1;
      logic [15:0] rs2;
      logic [15:0] imm;
      logic [3:0]  rd;
      logic [11:0] ctrl;
      logic        ld;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_rs1, in_rs2, in_rd;
   logic [15:0] in_imm;
   logic [11:0] in_ctrl;
   logic        in_is_load;
   logic        wb_we;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_rs1_data, out_rs2_data, out_imm;
   logic [3:0]  out_rd;
   logic [11:0] out_ctrl;
   logic        out_is_load;
   logic [15:0] stall_cnt;

   exp_t        sb[$];
   exp_t        m_out;
   logic [15:0] mregs [16];
   logic        m_ov;
   logic [15:0] m_stall;
   int          n_checks = 0;
   int          n_fail   = 0;

   id_regread_stage #(
      .DATA_W(16), .NUM_REGS(16), .ADDR_W(4), .ZERO_REG(15), .CTRL_W(12)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_imm(in_imm), .in_ctrl(in_ctrl), .in_is_load(in_is_load),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_imm(out_imm), .out_rd(out_rd), .out_ctrl(out_ctrl),
      .out_is_load(out_is_load), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Hard stop in case the sequence never completes.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] m_read(input logic [3:0] a);
      if (a == ZR) return 16'h0000;
      if (wb_we && (wb_addr == a)) return wb_data;
      return mregs[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mregs[i] = 16'h0000;
      m_ov    = 1'b0;
      m_stall = 16'h0000;
      m_out   = '{rs1: 16'h0000, rs2: 16'h0000, imm: 16'h0000, rd: ZR, ctrl: 12'h000, ld: 1'b0};
      sb.delete();
   endtask

   task automatic set_instr(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                            input logic [3:0] rd, input logic [15:0] imm,
                            input logic [11:0] ctrl, input logic ld);
      in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      in_imm = imm; in_ctrl = ctrl; in_is_load = ld;
   endtask

   task automatic set_wb(input logic we, input logic [3:0] a, input logic [15:0] d);
      wb_we = we; wb_addr = a; wb_data = d;
   endtask

   // One clock of stimulus: predict and check in_ready, push accepted
   // instructions, advance the model at the edge and check outputs after it.
   task automatic cycle();
      logic hz, adv, rdy, xfer;
      exp_t e;
      @(negedge clk);
      hz   = m_ov && m_out.ld && (m_out.rd != ZR) && in_valid &&
             ((in_rs1 == m_out.rd) || (in_rs2 == m_out.rd));
      adv  = out_ready || !m_ov;
      rdy  = adv && !hz && !flush;
      xfer = in_valid && rdy;
      n_checks++;
      if (in_ready !== rdy) begin
         n_fail++;
         $display("FAIL in_ready: got %b expected %b at %0t", in_ready, rdy, $time);
      end
      if (xfer) begin
         e.rs1 = m_read(in_rs1); e.rs2 = m_read(in_rs2); e.imm = in_imm;
         e.rd = in_rd; e.ctrl = in_ctrl; e.ld = in_is_load;
         sb.push_back(e);
      end
      @(posedge clk);
      if (hz && out_ready && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'h0001;
      if (flush) m_ov = 1'b0;
      else if (xfer) m_ov = 1'b1;
      else if (adv) m_ov = 1'b0;
      if (xfer) begin
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: empty queue at %0t", $time);
         end else begin
            m_out = sb.pop_front();
         end
      end
      if (wb_we && (wb_addr != ZR)) mregs[wb_addr] = wb_data;
      #1;
      n_checks += 8;
      if (out_valid !== m_ov) begin n_fail++; $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_ov, $time); end
      if (stall_cnt !== m_stall) begin n_fail++; $display("FAIL stall_cnt: got %0d expected %0d at %0t", stall_cnt, m_stall, $time); end
      if (out_rs1_data !== m_out.rs1) begin n_fail++; $display("FAIL out_rs1_data: got %h expected %h at %0t", out_rs1_data, m_out.rs1, $time); end
      if (out_rs2_data !== m_out.rs2) begin n_fail++; $display("FAIL out_rs2_data: got %h expected %h at %0t", out_rs2_data, m_out.rs2, $time); end
      if (out_imm !== m_out.imm) begin n_fail++; $display("FAIL out_imm: got %h expected %h at %0t", out_imm, m_out.imm, $time); end
      if (out_rd !== m_out.rd) begin n_fail++; $display("FAIL out_rd: got %h expected %h at %0t", out_rd, m_out.rd, $time); end
      if (out_ctrl !== m_out.ctrl) begin n_fail++; $display("FAIL out_ctrl: got %h expected %h at %0t", out_ctrl, m_out.ctrl, $time); end
      if (out_is_load !== m_out.ld) begin n_fail++; $display("FAIL out_is_load: got %b expected %b at %0t", out_is_load, m_out.ld, $time); end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      set_instr(1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 12'h000, 1'b0);
      set_wb(1'b0, 4'd0, 16'h0000);
      flush = 1'b0; out_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      model_reset();
      n_checks += 4;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      if (out_rd !== ZR) begin n_fail++; $display("FAIL reset_out_rd: got %h expected %h", out_rd, ZR); end
      if (stall_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
      if ((out_rs1_data | out_rs2_data | out_imm) !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h/%h/%h expected 0", out_rs1_data, out_rs2_data, out_imm); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_regfile_read();
      set_wb(1'b1, 4'd3, 16'h00A5);
      cycle();
      set_wb(1'b0, 4'd0, 16'h0000);
      set_instr(1'b1, 4'd3, 4'd15, 4'd1, 16'h0010, 12'h011, 1'b0);
      cycle();
      n_checks += 2;
      if (out_rs1_data !== 16'h00A5) begin n_fail++; $display("FAIL read_rs1: got %h expected 00a5", out_rs1_data); end
      if (out_rs2_data !== 16'h0000) begin n_fail++; $display("FAIL read_zero_rs2: got %h expected 0000", out_rs2_data); end
      set_instr(1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 12'h000, 1'b0);
      cycle();
   endtask

   task automatic test_zero_reg();
      set_wb(1'b1, 4'd15, 16'hFFFF);
      cycle();
      set_wb(1'b0, 4'd0, 16'h0000);
      set_instr(1'b1, 4'd15, 4'd15, 4'd2, 16'h0020, 12'h022, 1'b0);
      cycle();
      n_checks++;
      if (out_rs1_data !== 16'h0000) begin n_fail++; $display("FAIL zero_reg_write: got %h expected 0000", out_rs1_data); end
      set_instr(1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 12'h000, 1'b0);
      cycle();
   endtask

   task automatic test_load_use();
      set_wb(1'b1, 4'd2, 16'h0BEE);
      cycle();
      set_wb(1'b0, 4'd0, 16'h0000);
      set_instr(1'b1, 4'd0, 4'd1, 4'd2, 16'h0030, 12'h033, 1'b1);
      cycle();
      set_instr(1'b1, 4'd2, 4'd0, 4'd3, 16'h0040, 12'h044, 1'b0);
      cycle();
      n_checks += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL load_use_bubble: got out_valid %b expected 0", out_valid); end
      if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt); end
      cycle();
      n_checks += 2;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL load_use_issue: got out_valid %b expected 1", out_valid); end
      if (out_imm !== 16'h0040) begin n_fail++; $display("FAIL load_use_imm: got %h expected 0040", out_imm); end
      set_instr(1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 12'h000, 1'b0);
      cycle();
   endtask

   task automatic test_backpressure();
      set_instr(1'b1, 4'd1, 4'd2, 4'd6, 16'h5A5A, 12'hABC, 1'b0);
      cycle();
      out_ready = 1'b0;
      set_instr(1'b1, 4'd0, 4'd0, 4'd7, 16'h1111, 12'h123, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks += 3;
         if (out_imm !== 16'h5A5A) begin n_fail++; $display("FAIL hold_imm: got %h expected 5a5a", out_imm); end
         if (out_rd !== 4'd6) begin n_fail++; $display("FAIL hold_rd: got %h expected 6", out_rd); end
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %b expected 0", in_ready); end
      end
      out_ready = 1'b1;
      cycle();
      n_checks++;
      if (out_imm !== 16'h1111) begin n_fail++; $display("FAIL release_imm: got %h expected 1111", out_imm); end
      set_instr(1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 12'h000, 1'b0);
      cycle();
   endtask

   task automatic test_flush();
      set_instr(1'b1, 4'd0, 4'd0, 4'd8, 16'h2222, 12'h222, 1'b0);
      cycle();
      set_instr(1'b1, 4'd0, 4'd0, 4'd9, 16'h3333, 12'h333, 1'b0);
      flush = 1'b1;
      cycle();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
      flush = 1'b0;
      cycle();
      n_checks += 2;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_retry_valid: got %b expected 1", out_valid); end
      if (out_imm !== 16'h3333) begin n_fail++; $display("FAIL flush_retry_imm: got %h expected 3333", out_imm); end
      set_instr(1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 12'h000, 1'b0);
      cycle();
   endtask

   task automatic test_wb_bypass();
      set_wb(1'b1, 4'd5, 16'h1234);
      set_instr(1'b1, 4'd0, 4'd5, 4'd10, 16'h0050, 12'h055, 1'b0);
      cycle();
      n_checks++;
      if (out_rs2_data !== 16'h1234) begin n_fail++; $display("FAIL bypass_rs2: got %h expected 1234", out_rs2_data); end
      set_wb(1'b0, 4'd0, 16'h0000);
      set_instr(1'b1, 4'd5, 4'd0, 4'd10, 16'h0051, 12'h056, 1'b0);
      cycle();
      n_checks++;
      if (out_rs1_data !== 16'h1234) begin n_fail++; $display("FAIL bypass_stored: got %h expected 1234", out_rs1_data); end
      set_instr(1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 12'h000, 1'b0);
      cycle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         in_rs1     = ($urandom_range(0, 7) == 0) ? ZR : 4'($urandom_range(0, 3));
         in_rs2     = ($urandom_range(0, 7) == 0) ? ZR : 4'($urandom_range(0, 3));
         in_rd      = ($urandom_range(0, 7) == 0) ? ZR : 4'($urandom_range(0, 3));
         in_imm     = 16'($urandom);
         in_ctrl    = 12'($urandom);
         in_is_load = ($urandom_range(0, 1) != 0);
         wb_we      = ($urandom_range(0, 1) != 0);
         wb_addr    = 4'($urandom);
         wb_data    = 16'($urandom);
         flush      = ($urandom_range(0, 15) == 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         cycle();
      end
      set_instr(1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 12'h000, 1'b0);
      set_wb(1'b0, 4'd0, 16'h0000);
      flush = 1'b0; out_ready = 1'b1;
      cycle();
   endtask

   task automatic test_reset_mid_stall();
      set_wb(1'b1, 4'd4, 16'h7777);
      cycle();
      set_wb(1'b0, 4'd0, 16'h0000);
      set_instr(1'b1, 4'd0, 4'd0, 4'd4, 16'h0060, 12'h066, 1'b1);
      cycle();
      out_ready = 1'b0;
      set_instr(1'b1, 4'd4, 4'd0, 4'd11, 16'h0070, 12'h077, 1'b0);
      cycle();
      rst = 1'b1;
      #1;
      model_reset();
      n_checks += 3;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midstall_reset_valid: got %b expected 0", out_valid); end
      if (out_rd !== ZR) begin n_fail++; $display("FAIL midstall_reset_rd: got %h expected %h", out_rd, ZR); end
      if (stall_cnt !== 16'h0000) begin n_fail++; $display("FAIL midstall_reset_stall: got %0d expected 0", stall_cnt); end
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      cycle();
      n_checks += 2;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL after_reset_issue: got %b expected 1", out_valid); end
      if (out_rs1_data !== 16'h0000) begin n_fail++; $display("FAIL after_reset_reg_cleared: got %h expected 0000", out_rs1_data); end
      set_instr(1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 12'h000, 1'b0);
      cycle();
   endtask

   initial begin
      test_reset();
      test_regfile_read();
      test_zero_reg();
      test_load_use();
      test_backpressure();
      test_flush();
      test_wb_bypass();
      test_random();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
